// File: rtl/store_buffer_pkg.sv
// Shared sizing for the posted-write store buffer.
// Default geometry used by store_buffer and its match unit.
package store_buffer_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 32;
    localparam int SB_DW    = 32;

endpackage

// File: rtl/store_buffer_match.sv
// Youngest-first address match over the store buffer entries.
// Scans oldest to youngest so the last hit found is the youngest.
module store_buffer_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int PW    = $clog2(SB_DEPTH)
) (
    input  logic [DEPTH-1:0][AW-1:0] entry_addr,
    input  logic [DEPTH-1:0]         valid,
    input  logic [PW-1:0]            rd_ptr,
    input  logic [AW-1:0]            addr,
    output logic                     hit,
    output logic [PW-1:0]            hit_idx
);

    logic [PW-1:0] idx;

    // Priority search: later (younger) matches override older ones.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (valid[idx] && (entry_addr[idx] == addr)) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the MEM stage and Data_Memory.
// Stores queue and drain on free port cycles; loads forward from it.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] write_data_i,
    input  logic          MemRead_i,
    input  logic          MemWrite_i,
    input  logic          flush_i,
    output logic [DW-1:0] data_o,
    output logic          stall_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_data_o,
    output logic          mem_read_o,
    output logic          mem_write_o,
    input  logic [DW-1:0] mem_data_i
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [DEPTH-1:0][AW-1:0] addr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [PW:0]              count;
    logic [DEPTH-1:0]         valid;
    logic [PW-1:0]            off;
    logic                     empty;
    logic                     full;
    logic                     drain;
    logic                     enq;
    logic                     load;
    logic                     hit;
    logic [PW-1:0]            hit_idx;
    logic                     fwd_sel_q;
    logic [DW-1:0]            fwd_data_q;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // A raw MemRead_i keeps the port busy, even alongside an illegal store.
    assign drain   = !empty && (!MemRead_i || flush_i || full);
    assign stall_o = (flush_i && !empty)
                   || (MemWrite_i && full && !drain)
                   || (MemRead_i && full);
    assign enq     = MemWrite_i && !stall_o;
    assign load    = MemRead_i && !MemWrite_i && !stall_o;

    // An entry is live if its distance from the head is below count.
    always_comb begin
        valid = '0;
        off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off      = PW'(i) - rd_ptr;
            valid[i] = ({1'b0, off} < count);
        end
    end

    store_buffer_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .PW    (PW)
    ) u_match (
        .entry_addr (addr_q),
        .valid      (valid),
        .rd_ptr     (rd_ptr),
        .addr       (addr_i),
        .hit        (hit),
        .hit_idx    (hit_idx)
    );

    // Port mux: a drain owns the port; otherwise an accepted load does.
    always_comb begin
        mem_addr_o  = addr_i;
        mem_data_o  = data_q[rd_ptr];
        mem_read_o  = load;
        mem_write_o = drain;
        if (drain) begin
            mem_addr_o = addr_q[rd_ptr];
        end
    end

    // Entry storage; contents are don't-care until counted as live.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            addr_q[wr_ptr] <= addr_i;
            data_q[wr_ptr] <= write_data_i;
        end
    end

    // Pointer and occupancy tracking; a full enqueue+pop keeps count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (drain) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (PW+1)'(enq) - (PW+1)'(drain);
        end
    end

    // Forwarding select/data captured only on accepted loads.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fwd_sel_q  <= 1'b0;
            fwd_data_q <= '0;
        end else if (load) begin
            fwd_sel_q  <= hit;
            fwd_data_q <= data_q[hit_idx];
        end
    end

    assign data_o = fwd_sel_q ? fwd_data_q : mem_data_i;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a small Data_Memory model.
// Expected values are hand-derived or taken from a bench-side ref memory.
module tb_store_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] addr_i;
    logic [31:0] write_data_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic        flush_i;
    logic [31:0] data_o;
    logic        stall_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [31:0] mem_data_i;

    logic [31:0] mem     [0:127];
    logic [31:0] ref_mem [0:127];
    logic        mem_init;
    int          n_vec = 0;
    int          n_bad = 0;

    store_buffer dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .addr_i       (addr_i),
        .write_data_i (write_data_i),
        .MemRead_i    (MemRead_i),
        .MemWrite_i   (MemWrite_i),
        .flush_i      (flush_i),
        .data_o       (data_o),
        .stall_o      (stall_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .mem_data_i   (mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    // Data_Memory model: commits writes on negedge.
    always @(negedge clk_i) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'hF000_0000 | i;
        end else if (mem_write_o) begin
            mem[mem_addr_o[8:2]] <= mem_data_o;
        end
    end

    // Data_Memory model: registered read port.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) mem_data_i <= '0;
        else if (mem_read_o) mem_data_i <= mem[mem_addr_o[8:2]];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit rd, input bit wr, input bit fl,
                         input logic [31:0] a, input logic [31:0] d);
        MemRead_i    = rd;
        MemWrite_i   = wr;
        flush_i      = fl;
        addr_i       = a;
        write_data_i = d;
    endtask

    task automatic idle();
        drive(0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d,
                      input bit busy);
        drive(busy, 1, 0, a, d);
        ref_mem[a[8:2]] = d;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic [31:0] a;
        rst_i    = 1'b1;
        mem_init = 1'b1;
        idle();
        for (int i = 0; i < 128; i++) ref_mem[i] = 32'hF000_0000 | i;
        repeat (2) tick();
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_data", data_o, 32'd0);
        chk("rst_wr", 32'(mem_write_o), 32'd0);
        mem_init = 1'b0;
        rst_i    = 1'b0;
        tick();

        // store, drain on idle, load back from memory
        st(32'h8, 32'h1122_3344, 0);
        settle();
        chk("t1_stall", 32'(stall_o), 32'd0);
        tick();
        idle();
        settle();
        chk("t1_mwr", 32'(mem_write_o), 32'd1);
        chk("t1_maddr", mem_addr_o, 32'h8);
        chk("t1_mdata", mem_data_o, 32'h1122_3344);
        tick();
        drive(1, 0, 0, 32'h8, 32'h0);
        settle();
        chk("t1_mrd", 32'(mem_read_o), 32'd1);
        tick();
        idle();
        settle();
        chk("t1_load", data_o, 32'h1122_3344);
        chk("t1_fwdsel", 32'(dut.fwd_sel_q), 32'd0);
        tick();

        // two stores to one address, youngest forwarded
        st(32'h4, 32'hAAAA_0001, 1);
        tick();
        st(32'h4, 32'hAAAA_0002, 1);
        settle();
        chk("t2_nodrain_st", 32'(mem_write_o), 32'd0);
        tick();
        drive(1, 0, 0, 32'h4, 32'h0);
        settle();
        chk("t2_nodrain_ld", 32'(mem_write_o), 32'd0);
        chk("t2_count", 32'(dut.count), 32'd2);
        tick();
        idle();
        settle();
        chk("t2_fwd", data_o, 32'hAAAA_0002);
        chk("t2_fwdsel", 32'(dut.fwd_sel_q), 32'd1);
        tick();
        tick();
        chk("t2_mem", mem[1], 32'hAAAA_0002);
        chk("t2_empty", 32'(dut.count), 32'd0);

        // fill while the port is busy, then full-buffer cases
        for (int i = 0; i < 4; i++) begin
            st(32'h40 + 32'(4 * i), 32'h5000_0000 + 32'(i), 1);
            tick();
        end
        chk("t3_full", 32'(dut.count), 32'd4);
        st(32'h50, 32'h5000_0004, 0);
        settle();
        chk("t3_nostall", 32'(stall_o), 32'd0);
        chk("t3_pop_wr", 32'(mem_write_o), 32'd1);
        chk("t3_pop_addr", mem_addr_o, 32'h40);
        tick();
        chk("t3_cnt_hold", 32'(dut.count), 32'd4);
        st(32'h54, 32'h5000_0005, 1);
        settle();
        chk("t3_stall", 32'(stall_o), 32'd1);
        chk("t3_stall_addr", mem_addr_o, 32'h44);
        tick();
        chk("t3_stall_1cyc", 32'(stall_o), 32'd0);
        chk("t3_cnt3", 32'(dut.count), 32'd3);
        tick();
        chk("t3_cnt4", 32'(dut.count), 32'd4);
        drive(0, 0, 1, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t3_flush_stall", 32'(stall_o), 32'd1);
            tick();
        end
        chk("t3_flush_done", 32'(stall_o), 32'd0);
        chk("t3_flush_cnt", 32'(dut.count), 32'd0);
        idle();
        tick();
        for (int i = 0; i < 6; i++) begin
            a = 32'h40 + 32'(4 * i);
            chk("t3_mem", mem[a[8:2]], ref_mem[a[8:2]]);
        end

        // loads every cycle starve drain until flush
        st(32'h60, 32'h6000_0000, 1);
        tick();
        st(32'h64, 32'h6000_0001, 1);
        tick();
        drive(1, 0, 0, 32'h100, 32'h0);
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("t4_nodrain", 32'(mem_write_o), 32'd0);
            chk("t4_rd", 32'(mem_read_o), 32'd1);
            tick();
        end
        drive(1, 0, 1, 32'h100, 32'h0);
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("t4_fl_stall", 32'(stall_o), 32'd1);
            chk("t4_fl_wr", 32'(mem_write_o), 32'd1);
            chk("t4_fl_rd", 32'(mem_read_o), 32'd0);
            tick();
        end
        settle();
        chk("t4_c3_stall", 32'(stall_o), 32'd0);
        chk("t4_c3_cnt", 32'(dut.count), 32'd0);
        chk("t4_c3_rd", 32'(mem_read_o), 32'd1);
        tick();
        idle();
        settle();
        chk("t4_load", data_o, ref_mem[64]);
        chk("t4_mem60", mem[24], 32'h6000_0000);
        chk("t4_mem64", mem[25], 32'h6000_0001);
        tick();

        // pointer wrap: store, forwarded load, drain
        for (int i = 0; i < 10; i++) begin
            a = 32'(4 * i);
            st(a, 32'hC0DE_0000 + 32'(i), 0);
            tick();
            drive(1, 0, 0, a, 32'h0);
            tick();
            idle();
            settle();
            chk("t5_fwd", data_o, ref_mem[a[8:2]]);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            chk("t5_mem", mem[i], ref_mem[i]);
        end

        // reset while draining discards queued stores
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 32'h80 + 32'(4 * i), 32'hBAD0_0000 + 32'(i));
            tick();
        end
        idle();
        settle();
        chk("t6_draining", 32'(mem_write_o), 32'd1);
        rst_i = 1'b1;
        #1;
        chk("t6_cnt", 32'(dut.count), 32'd0);
        chk("t6_stall", 32'(stall_o), 32'd0);
        chk("t6_data", data_o, 32'd0);
        chk("t6_wr", 32'(mem_write_o), 32'd0);
        tick();
        rst_i = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t6_mem", mem[32 + i], ref_mem[32 + i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
